// File: rtl/pulpemu_uart_bidir.sv
// APB-programmed 8N1 UART: synchronised RX FSM feeding an RX FIFO, optional TX FIFO + TX FSM.
// TX path is compiled only when PULPEMU_UART_TX_EN is defined; otherwise TX reads as idle/empty.
module pulpemu_uart_bidir #(
    parameter int          RX_FIFO_DEPTH = 16,
    parameter int          TX_FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET     = 16'd867
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] apb_paddr,
    input  logic        apb_psel,
    input  logic        apb_penable,
    input  logic        apb_pwrite,
    input  logic [31:0] apb_pwdata,
    output logic [31:0] apb_prdata,
    output logic        apb_pready,
    output logic        apb_pslverr,
    output logic        irq_o,
    input  logic        uart_rx_i,
    output logic        uart_tx_o
);
    localparam int RXAW = $clog2(RX_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [15:0] div;
    logic        en;
    logic [2:0]  irqen;
    logic        frame_err, overrun;
    logic        access, wr, rd, abort;
    logic [4:0]  addr;
    logic [15:0] div_eff;
    logic        tx_busy, tx_full, tx_empty;
    logic [15:0] tx_level;

    assign apb_pready  = 1'b1;
    assign apb_pslverr = 1'b0;
    assign addr    = apb_paddr[4:0];
    assign access  = apb_psel & apb_penable;
    assign wr      = access & apb_pwrite;
    assign rd      = access & ~apb_pwrite;
    assign div_eff = (div < 16'd3) ? 16'd3 : div;
    // Writing en=0 must idle both FSMs on the very next edge, not one later.
    assign abort   = ~en | (wr & (addr == 5'h04) & ~apb_pwdata[15]);

    logic unused;
    assign unused = ^{apb_paddr[31:5], apb_pwdata[14:3]};

    logic rx_s1, rx_s2, rx_prev;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx_i;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    logic [7:0]  rx_mem [RX_FIFO_DEPTH];
    logic [RXAW:0] rx_wptr, rx_rptr, rx_count;
    logic        rx_empty, rx_full, rx_pop, rx_push, rx_stop_smp;
    state_t      rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;

    assign rx_count    = rx_wptr - rx_rptr;
    assign rx_empty    = (rx_count == '0);
    assign rx_full     = (rx_count == (RXAW+1)'(RX_FIFO_DEPTH));
    assign rx_pop      = rd & (addr == 5'h00) & ~rx_empty;
    assign rx_stop_smp = (rx_state == STOP) & (rx_cnt == div_eff) & ~abort;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
    assign rx_push     = rx_stop_smp & rx_s2 & (~rx_full | rx_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else if (abort) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
        end else begin
            case (rx_state)
                IDLE: if (rx_prev & ~rx_s2) begin
                    rx_state <= START;
                    rx_cnt   <= '0;
                end
                START: if (rx_cnt == {1'b0, div_eff[15:1]}) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s2 ? IDLE : DATA;
                end else rx_cnt <= rx_cnt + 16'd1;
                DATA: if (rx_cnt == div_eff) begin
                    rx_cnt <= '0;
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state <= STOP;
                end else rx_cnt <= rx_cnt + 16'd1;
                STOP: if (rx_cnt == div_eff) begin
                    rx_cnt   <= '0;
                    rx_state <= IDLE;
                end else rx_cnt <= rx_cnt + 16'd1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr[RXAW-1:0]] <= rx_sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wptr   <= '0;
            rx_rptr   <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            frame_err <= (rx_stop_smp & ~rx_s2) |
                         (frame_err & ~(wr & (addr == 5'h0C) & apb_pwdata[0]));
            overrun   <= (rx_stop_smp & rx_s2 & rx_full & ~rx_pop) |
                         (overrun & ~(wr & (addr == 5'h0C) & apb_pwdata[1]));
        end
    end

`ifdef PULPEMU_UART_TX_EN
    localparam int TXAW = $clog2(TX_FIFO_DEPTH);

    logic [7:0]  tx_mem [TX_FIFO_DEPTH];
    logic [TXAW:0] tx_wptr, tx_rptr, tx_count;
    logic        tx_push, tx_pop;
    state_t      tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_sh;
    logic        tx_line;

    assign tx_count  = tx_wptr - tx_rptr;
    assign tx_empty  = (tx_count == '0);
    assign tx_full   = (tx_count == (TXAW+1)'(TX_FIFO_DEPTH));
    assign tx_level  = 16'(tx_count);
    assign tx_push   = wr & (addr == 5'h10) & ~tx_full;
    assign tx_pop    = (tx_state == IDLE) & ~abort & ~tx_empty;
    assign tx_busy   = (tx_state != IDLE);
    assign uart_tx_o = tx_line;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr[TXAW-1:0]] <= apb_pwdata[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_line  <= 1'b1;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            if (abort) begin
                tx_state <= IDLE;
                tx_cnt   <= '0;
                tx_line  <= 1'b1;
            end else begin
                case (tx_state)
                    IDLE: if (tx_pop) begin
                        tx_sh    <= tx_mem[tx_rptr[TXAW-1:0]];
                        tx_cnt   <= '0;
                        tx_line  <= 1'b0;
                        tx_state <= START;
                    end
                    START: if (tx_cnt == div_eff) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_line  <= tx_sh[0];
                        tx_state <= DATA;
                    end else tx_cnt <= tx_cnt + 16'd1;
                    DATA: if (tx_cnt == div_eff) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_line  <= 1'b1;
                            tx_state <= STOP;
                        end else begin
                            tx_bit  <= tx_bit + 3'd1;
                            tx_sh   <= {1'b0, tx_sh[7:1]};
                            tx_line <= tx_sh[1];
                        end
                    end else tx_cnt <= tx_cnt + 16'd1;
                    STOP: if (tx_cnt == div_eff) begin
                        tx_cnt   <= '0;
                        tx_state <= IDLE;
                    end else tx_cnt <= tx_cnt + 16'd1;
                endcase
            end
        end
    end
`else
    logic unused_tx;
    assign unused_tx = (TX_FIFO_DEPTH < 2);
    assign tx_empty  = 1'b1;
    assign tx_full   = 1'b0;
    assign tx_busy   = 1'b0;
    assign tx_level  = 16'h0;
    assign uart_tx_o = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div   <= DIV_RESET;
            en    <= 1'b0;
            irqen <= 3'b000;
            irq_o <= 1'b0;
        end else begin
            if (wr && addr == 5'h04) begin
                div <= apb_pwdata[31:16];
                en  <= apb_pwdata[15];
            end
`ifdef PULPEMU_UART_TX_EN
            if (wr && addr == 5'h14) irqen <= apb_pwdata[2:0];
`else
            if (wr && addr == 5'h14) irqen <= {apb_pwdata[2], 1'b0, apb_pwdata[0]};
`endif
            irq_o <= (irqen[0] & ~rx_empty) | (irqen[1] & tx_empty & ~tx_busy) |
                     (irqen[2] & (frame_err | overrun));
        end
    end

    always_comb begin
        apb_prdata = '0;
        if (access && !rst) begin
            case (addr)
                5'h00: if (!rx_empty) apb_prdata = {24'h0, rx_mem[rx_rptr[RXAW-1:0]]};
                5'h04: apb_prdata = {div, en, 15'h0};
                5'h08: apb_prdata = {27'h0, tx_busy, tx_full, overrun, frame_err, ~rx_empty};
                5'h14: apb_prdata = {29'h0, irqen};
                5'h18: apb_prdata = {tx_level, 16'(rx_count)};
                default: apb_prdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_pulpemu_uart_bidir.sv
// Scoreboard bench for pulpemu_uart_bidir: serial frames in, APB reads checked against a byte queue.
module tb_pulpemu_uart_bidir;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] apb_paddr, apb_pwdata, apb_prdata;
    logic        apb_psel, apb_penable, apb_pwrite, apb_pready, apb_pslverr;
    logic        irq_o, uart_rx_i, uart_tx_o;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    pulpemu_uart_bidir dut (
        .clk(clk), .rst(rst),
        .apb_paddr(apb_paddr), .apb_psel(apb_psel), .apb_penable(apb_penable),
        .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
        .apb_pready(apb_pready), .apb_pslverr(apb_pslverr),
        .irq_o(irq_o), .uart_rx_i(uart_rx_i), .uart_tx_o(uart_tx_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        apb_paddr = a; apb_pwdata = d; apb_pwrite = 1'b1; apb_psel = 1'b1; apb_penable = 1'b0;
        @(posedge clk); #1;
        apb_penable = 1'b1;
        @(posedge clk); #1;
        apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        apb_paddr = a; apb_pwrite = 1'b0; apb_psel = 1'b1; apb_penable = 1'b0;
        @(posedge clk); #1;
        apb_penable = 1'b1;
        @(negedge clk);
        d = apb_prdata;
        @(posedge clk); #1;
        apb_psel = 1'b0; apb_penable = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int cpb);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx_i = frame[i];
            repeat (cpb) @(posedge clk);
        end
        uart_rx_i = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic read_rx_and_score(input string name);
        logic [31:0] d;
        logic [7:0]  e;
        apb_read(32'h00, d);
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty got=%h", name, d);
        end else begin
            e = exp_q.pop_front();
            if (d !== {24'h0, e}) begin
                failures++;
                $display("FAIL %s rxdata got=%h exp=%h", name, d, {24'h0, e});
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; uart_rx_i = 1'b1;
        apb_paddr = 32'h04; apb_pwdata = '0; apb_pwrite = 1'b0; apb_psel = 1'b1; apb_penable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (uart_tx_o !== 1'b1 || irq_o !== 1'b0 || apb_prdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got tx=%b irq=%b prdata=%h exp tx=1 irq=0 prdata=0",
                     uart_tx_o, irq_o, apb_prdata);
        end
        checks++;
        if (apb_pready !== 1'b1 || apb_pslverr !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got pready=%b pslverr=%b exp 1/0", apb_pready, apb_pslverr);
        end
        apb_psel = 1'b0; apb_penable = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        apb_read(32'h04, d);
        checks++;
        if (d !== 32'h0363_0000) begin failures++; $display("FAIL reset_config got=%h exp=%h", d, 32'h0363_0000); end
        apb_read(32'h08, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", d); end
        apb_read(32'h18, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_level got=%h exp=0", d); end
        apb_read(32'h14, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_irqen got=%h exp=0", d); end
    endtask

    task automatic test_rx();
        logic [31:0] d;
        apb_write(32'h04, 32'h0009_8000);
        send_byte(8'h55, 1'b1, 10);
        exp_q.push_back(8'h55);
        apb_read(32'h08, d);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL rx_status_valid got=%h exp=1", d); end
        read_rx_and_score("rx_0x55");
        apb_read(32'h08, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL rx_status_after got=%h exp=0", d); end
        apb_read(32'h00, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL rx_empty_read got=%h exp=0", d); end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        @(posedge clk); #1;
        uart_rx_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 uart_rx_i = 1'b1;
        repeat (20) @(posedge clk);
        apb_read(32'h18, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL glitch_level got=%h exp=0", d); end
        apb_read(32'h08, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL glitch_status got=%h exp=0", d); end
        send_byte(8'h3C, 1'b1, 10);
        exp_q.push_back(8'h3C);
        read_rx_and_score("glitch_recover");
    endtask

    task automatic test_frame_err();
        logic [31:0] d;
        send_byte(8'hA3, 1'b0, 10);
        apb_read(32'h08, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL frame_status got=%h exp=2", d); end
        apb_read(32'h18, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL frame_level got=%h exp=0", d); end
        apb_write(32'h14, 32'h4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (irq_o !== 1'b1) begin failures++; $display("FAIL frame_irq got=%b exp=1", irq_o); end
        apb_write(32'h0C, 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (irq_o !== 1'b0) begin failures++; $display("FAIL frame_irq_clr got=%b exp=0", irq_o); end
        apb_read(32'h08, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL frame_status_clr got=%h exp=0", d); end
        apb_write(32'h14, 32'h0);
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i * 7 + 1), 1'b1, 10);
            if (i < 16) exp_q.push_back(8'(i * 7 + 1));
        end
        apb_read(32'h18, d);
        checks++;
        if (d !== 32'h0000_0010) begin failures++; $display("FAIL overrun_level got=%h exp=10", d); end
        apb_read(32'h08, d);
        checks++;
        if (d !== 32'h5) begin failures++; $display("FAIL overrun_status got=%h exp=5", d); end
        for (int i = 0; i < 16; i++) read_rx_and_score("overrun_drain");
        apb_write(32'h0C, 32'h2);
        apb_read(32'h08, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL overrun_clr got=%h exp=0", d); end
    endtask

    task automatic test_tx();
        logic [31:0] d;
`ifdef PULPEMU_UART_TX_EN
        logic [9:0] exp_bits;
        bit found;
        exp_bits = {1'b1, 8'h0F, 1'b0};
        apb_write(32'h04, 32'h0003_8000);
        apb_write(32'h10, 32'h0000_000F);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (uart_tx_o === 1'b0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL tx_start_timeout got tx=%b exp=0 within 50 cycles", uart_tx_o);
        end else begin
            @(negedge clk);
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (uart_tx_o !== exp_bits[k]) begin
                    failures++;
                    $display("FAIL tx_bit%0d got=%b exp=%b", k, uart_tx_o, exp_bits[k]);
                end
                if (k < 9) repeat (4) @(negedge clk);
            end
        end
        repeat (4) @(posedge clk);
        apb_read(32'h08, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL tx_status_idle got=%h exp=0", d); end
        apb_write(32'h14, 32'h2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (irq_o !== 1'b1) begin failures++; $display("FAIL tx_empty_irq got=%b exp=1", irq_o); end
        apb_write(32'h14, 32'h0);
`else
        bit stayed_high;
        apb_write(32'h10, 32'h0000_00AA);
        stayed_high = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (uart_tx_o !== 1'b1) stayed_high = 1'b0;
        end
        checks++;
        if (!stayed_high) begin failures++; $display("FAIL notx_line got=low exp=always 1"); end
        apb_read(32'h18, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL notx_level got=%h exp=0", d); end
        apb_write(32'h14, 32'h7);
        apb_read(32'h14, d);
        checks++;
        if (d !== 32'h5) begin failures++; $display("FAIL notx_irqen got=%h exp=5", d); end
        apb_write(32'h14, 32'h0);
`endif
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        logic [7:0]  b;
        apb_write(32'h04, 32'h0009_8000);
        send_byte(8'h81, 1'b1, 10);
        apb_read(32'h18, d);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL midrst_pre_level got=%h exp=1", d); end
        apb_write(32'h14, 32'h1);
        b = 8'h5A;
        uart_rx_i = 1'b0;
        repeat (10) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx_i = b[i];
            repeat (10) @(posedge clk);
        end
        uart_rx_i = b[4];
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (uart_tx_o !== 1'b1 || irq_o !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs got tx=%b irq=%b exp tx=1 irq=0", uart_tx_o, irq_o);
        end
        repeat (3) @(posedge clk);
        #1 uart_rx_i = 1'b1; rst = 1'b0;
        repeat (20) @(posedge clk);
        apb_read(32'h18, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL midrst_level got=%h exp=0", d); end
        apb_read(32'h04, d);
        checks++;
        if (d !== 32'h0363_0000) begin failures++; $display("FAIL midrst_config got=%h exp=03630000", d); end
        @(negedge clk);
        checks++;
        if (irq_o !== 1'b0 || uart_tx_o !== 1'b1) begin
            failures++;
            $display("FAIL midrst_after got irq=%b tx=%b exp irq=0 tx=1", irq_o, uart_tx_o);
        end
    endtask

    initial begin
        test_reset();
        test_rx();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_tx();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
